// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for an RV32 core.
//   clk_i / rst_i            clock, synchronous active-high reset
//   raddr_i -> rdata_o       combinational CSR read
//   we_i, waddr_i, wdata_i   CSR write, applied at the next clock edge
//   illegal_csr_o            unmapped read, or write to a read-only/unmapped address
//   instret_i                one instruction retired this cycle
//   irq_*_i                  asynchronous interrupt lines, synchronized into mip
//   ie_type_i, set_cause_i, trap_cause_i, set_epc_i, epc_i,
//   set_mtval_i, mtval_i, mstatus_ie_clear_i, mstatus_ie_set_i
//                            trap entry / mret updates from pipeline control
//   mstatus_ie_o, mie_*_o, mip_*_o, mtvec_o, epc_o
//                            state fed back to pipeline control
module csr_file #(
   parameter int unsigned HART_ID     = 0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [11:0] raddr_i,
   output logic [31:0] rdata_o,
   input  logic        we_i,
   input  logic [11:0] waddr_i,
   input  logic [31:0] wdata_i,
   output logic        illegal_csr_o,
   input  logic        instret_i,
   input  logic        irq_external_i,
   input  logic        irq_timer_i,
   input  logic        irq_software_i,
   input  logic        ie_type_i,
   input  logic        set_cause_i,
   input  logic [3:0]  trap_cause_i,
   input  logic        set_epc_i,
   input  logic [31:0] epc_i,
   input  logic        set_mtval_i,
   input  logic [31:0] mtval_i,
   input  logic        mstatus_ie_clear_i,
   input  logic        mstatus_ie_set_i,
   output logic        mstatus_ie_o,
   output logic        mie_external_o,
   output logic        mie_timer_o,
   output logic        mie_sw_o,
   output logic        mip_external_o,
   output logic        mip_timer_o,
   output logic        mip_sw_o,
   output logic [31:0] mtvec_o,
   output logic [31:0] epc_o
);

   // Interrupt bit triplets are ordered {external, timer, software}.
   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [2:0]  ie_q, ie_d;
   logic [2:0]  sync1_q, sync2_q, mip_q;
   logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
   logic        rd_ok, wr_ok, wr_en;

   // Combinational read; a same-cycle write is not visible until the edge.
   always_comb begin
      rdata_o = '0;
      rd_ok   = 1'b1;
      case (raddr_i)
         12'h300: rdata_o = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         12'h301: rdata_o = MISA_VALUE;
         12'h304: rdata_o = {20'b0, ie_q[2], 3'b0, ie_q[1], 3'b0, ie_q[0], 3'b0};
         12'h305: rdata_o = mtvec_q;
         12'h340: rdata_o = mscratch_q;
         12'h341: rdata_o = mepc_q;
         12'h342: rdata_o = mcause_q;
         12'h343: rdata_o = mtval_q;
         12'h344: rdata_o = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
         12'hB00, 12'hC00: rdata_o = mcycle_q[31:0];
         12'hB80, 12'hC80: rdata_o = mcycle_q[63:32];
         12'hB02, 12'hC02: rdata_o = minstret_q[31:0];
         12'hB82, 12'hC82: rdata_o = minstret_q[63:32];
         12'hF14: rdata_o = 32'(HART_ID);
         default: rd_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (waddr_i)
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'hB00, 12'hB80, 12'hB02, 12'hB82: wr_ok = 1'b1;
         default: wr_ok = 1'b0;
      endcase
   end

   assign wr_en         = we_i & wr_ok;
   assign illegal_csr_o = ~rd_ok | (we_i & ~wr_ok);

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      ie_d       = ie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'b0, instret_i};

      // Trap-side updates take priority over a software write to the same CSR.
      if (mstatus_ie_clear_i) begin
         mpie_d = mie_q;
         mie_d  = 1'b0;
      end else if (mstatus_ie_set_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (wr_en && waddr_i == 12'h300) begin
         mie_d  = wdata_i[3];
         mpie_d = wdata_i[7];
      end

      if (set_cause_i)
         mcause_d = {ie_type_i, 27'b0, trap_cause_i};
      else if (wr_en && waddr_i == 12'h342)
         mcause_d = {wdata_i[31], 27'b0, wdata_i[3:0]};

      if (set_epc_i)
         mepc_d = {epc_i[31:2], 2'b00};
      else if (wr_en && waddr_i == 12'h341)
         mepc_d = {wdata_i[31:2], 2'b00};

      if (set_mtval_i)
         mtval_d = mtval_i;
      else if (wr_en && waddr_i == 12'h343)
         mtval_d = wdata_i;

      if (wr_en) begin
         case (waddr_i)
            12'h304: ie_d       = {wdata_i[11], wdata_i[7], wdata_i[3]};
            12'h305: mtvec_d    = {wdata_i[31:2], 1'b0, wdata_i[0]};
            12'h340: mscratch_d = wdata_i;
            // A written half replaces the increment; the other half holds.
            12'hB00: mcycle_d   = {mcycle_q[63:32], wdata_i};
            12'hB80: mcycle_d   = {wdata_i, mcycle_q[31:0]};
            12'hB02: minstret_d = {minstret_q[63:32], wdata_i};
            12'hB82: minstret_d = {wdata_i, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         ie_q       <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         mip_q      <= '0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         ie_q       <= ie_d;
         sync1_q    <= {irq_external_i, irq_timer_i, irq_software_i};
         sync2_q    <= sync1_q;
         mip_q      <= sync2_q;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

   assign mstatus_ie_o   = mie_q;
   assign mie_external_o = ie_q[2];
   assign mie_timer_o    = ie_q[1];
   assign mie_sw_o       = ie_q[0];
   assign mip_external_o = mip_q[2];
   assign mip_timer_o    = mip_q[1];
   assign mip_sw_o       = mip_q[0];
   assign mtvec_o        = mtvec_q;
   assign epc_o          = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [11:0] raddr_i = '0;
   logic [31:0] rdata_o;
   logic        we_i = 1'b0;
   logic [11:0] waddr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        illegal_csr_o;
   logic        instret_i = 1'b0;
   logic        irq_external_i = 1'b0, irq_timer_i = 1'b0, irq_software_i = 1'b0;
   logic        ie_type_i = 1'b0, set_cause_i = 1'b0;
   logic [3:0]  trap_cause_i = '0;
   logic        set_epc_i = 1'b0;
   logic [31:0] epc_i = '0;
   logic        set_mtval_i = 1'b0;
   logic [31:0] mtval_i = '0;
   logic        mstatus_ie_clear_i = 1'b0, mstatus_ie_set_i = 1'b0;
   logic        mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o;
   logic        mip_external_o, mip_timer_o, mip_sw_o;
   logic [31:0] mtvec_o, epc_o;

   int n_chk = 0;
   int n_fail = 0;

   csr_file #(.HART_ID(3), .MTVEC_RESET(32'h0000_0100), .MISA_VALUE(32'h4000_0100)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .illegal_csr_o(illegal_csr_o),
      .instret_i(instret_i), .irq_external_i(irq_external_i), .irq_timer_i(irq_timer_i),
      .irq_software_i(irq_software_i), .ie_type_i(ie_type_i), .set_cause_i(set_cause_i),
      .trap_cause_i(trap_cause_i), .set_epc_i(set_epc_i), .epc_i(epc_i),
      .set_mtval_i(set_mtval_i), .mtval_i(mtval_i), .mstatus_ie_clear_i(mstatus_ie_clear_i),
      .mstatus_ie_set_i(mstatus_ie_set_i), .mstatus_ie_o(mstatus_ie_o),
      .mie_external_o(mie_external_o), .mie_timer_o(mie_timer_o), .mie_sw_o(mie_sw_o),
      .mip_external_o(mip_external_o), .mip_timer_o(mip_timer_o), .mip_sw_o(mip_sw_o),
      .mtvec_o(mtvec_o), .epc_o(epc_o));

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      raddr_i = a;
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; wdata_i = d;
      tick();
      we_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      rd(12'hB00);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mcycle got %h exp 0", rdata_o); end
      rd(12'hB02);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_minstret got %h exp 0", rdata_o); end
      rd(12'h300);
      n_chk++; if (rdata_o !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus got %h exp 00001800", rdata_o); end
      n_chk++; if (illegal_csr_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got %b exp 0", illegal_csr_o); end
      rd(12'h305);
      n_chk++; if (rdata_o !== 32'h0000_0100 || mtvec_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_mtvec got %h/%h exp 00000100", rdata_o, mtvec_o); end
      rd(12'h342);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mcause got %h exp 0", rdata_o); end
      rd(12'h304);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_mie got %h exp 0", rdata_o); end
      rd(12'hF14);
      n_chk++; if (rdata_o !== 32'd3) begin n_fail++; $display("FAIL rst_mhartid got %h exp 3", rdata_o); end
      rd(12'h301);
      n_chk++; if (rdata_o !== 32'h4000_0100) begin n_fail++; $display("FAIL rst_misa got %h exp 40000100", rdata_o); end
      n_chk++; if ({mstatus_ie_o, mip_timer_o, epc_o} !== 34'h0) begin n_fail++; $display("FAIL rst_outs got %b %b %h exp 0", mstatus_ie_o, mip_timer_o, epc_o); end
   endtask

   task automatic test_mtvec_mepc();
      wr(12'h305, 32'h8000_0103);
      rd(12'h305);
      n_chk++; if (rdata_o !== 32'h8000_0101 || mtvec_o !== 32'h8000_0101) begin n_fail++; $display("FAIL mtvec got %h/%h exp 80000101", rdata_o, mtvec_o); end
      wr(12'h341, 32'h0000_1237);
      n_chk++; if (epc_o !== 32'h0000_1234) begin n_fail++; $display("FAIL mepc got %h exp 00001234", epc_o); end
      // no write bypass: the old value is visible until the edge
      rd(12'h340);
      we_i = 1'b1; waddr_i = 12'h340; wdata_i = 32'h0000_00A5;
      #1;
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL no_bypass got %h exp 0", rdata_o); end
      tick();
      we_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_00A5) begin n_fail++; $display("FAIL mscratch got %h exp 000000a5", rdata_o); end
   endtask

   task automatic test_mstatus();
      wr(12'h300, 32'hFFFF_FF08);
      rd(12'h300);
      n_chk++; if (rdata_o !== 32'h0000_1808 || mstatus_ie_o !== 1'b1) begin n_fail++; $display("FAIL ms_write got %h exp 00001808", rdata_o); end
      mstatus_ie_clear_i = 1'b1; tick(); mstatus_ie_clear_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_1880 || mstatus_ie_o !== 1'b0) begin n_fail++; $display("FAIL ms_clear got %h exp 00001880", rdata_o); end
      mstatus_ie_set_i = 1'b1; tick(); mstatus_ie_set_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_1888) begin n_fail++; $display("FAIL ms_set got %h exp 00001888", rdata_o); end
      mstatus_ie_clear_i = 1'b1; mstatus_ie_set_i = 1'b1; tick();
      mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_1880) begin n_fail++; $display("FAIL ms_both got %h exp 00001880", rdata_o); end
      // mret beats a software write of MIE=1,MPIE=0
      mstatus_ie_set_i = 1'b1; wr(12'h300, 32'h0000_0008); mstatus_ie_set_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_1888) begin n_fail++; $display("FAIL ms_set_vs_wr got %h exp 00001888", rdata_o); end
   endtask

   task automatic test_trap_priority();
      set_cause_i = 1'b1; ie_type_i = 1'b1; trap_cause_i = 4'hB;
      wr(12'h342, 32'h0000_0005);
      set_cause_i = 1'b0; ie_type_i = 1'b0;
      rd(12'h342);
      n_chk++; if (rdata_o !== 32'h8000_000B) begin n_fail++; $display("FAIL mcause got %h exp 8000000b", rdata_o); end
      set_epc_i = 1'b1; epc_i = 32'h0000_3003;
      wr(12'h341, 32'h0000_4444);
      set_epc_i = 1'b0;
      n_chk++; if (epc_o !== 32'h0000_3000) begin n_fail++; $display("FAIL epc_trap got %h exp 00003000", epc_o); end
      set_mtval_i = 1'b1; mtval_i = 32'h0000_DEAD;
      wr(12'h343, 32'h1111_1111);
      set_mtval_i = 1'b0;
      rd(12'h343);
      n_chk++; if (rdata_o !== 32'h0000_DEAD) begin n_fail++; $display("FAIL mtval got %h exp 0000dead", rdata_o); end
   endtask

   task automatic test_mip();
      wr(12'h304, 32'hFFFF_FFFF);
      rd(12'h304);
      n_chk++; if (rdata_o !== 32'h0000_0888) begin n_fail++; $display("FAIL mie_mask got %h exp 00000888", rdata_o); end
      wr(12'h304, 32'h0000_0080);
      n_chk++; if ({mie_external_o, mie_timer_o, mie_sw_o} !== 3'b010) begin n_fail++; $display("FAIL mie_bits got %b exp 010", {mie_external_o, mie_timer_o, mie_sw_o}); end
      rd(12'h344);
      irq_timer_i = 1'b1;
      tick();
      n_chk++; if (mip_timer_o !== 1'b0) begin n_fail++; $display("FAIL mip_edge1 got %b exp 0", mip_timer_o); end
      tick();
      n_chk++; if (mip_timer_o !== 1'b0) begin n_fail++; $display("FAIL mip_edge2 got %b exp 0", mip_timer_o); end
      tick();
      n_chk++; if (mip_timer_o !== 1'b1 || rdata_o !== 32'h0000_0080) begin n_fail++; $display("FAIL mip_edge3 got %b %h exp 1 00000080", mip_timer_o, rdata_o); end
      we_i = 1'b1; waddr_i = 12'h344; wdata_i = 32'h0;
      #1;
      n_chk++; if (illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL mip_wr_illegal got %b exp 1", illegal_csr_o); end
      tick();
      we_i = 1'b0;
      n_chk++; if (rdata_o !== 32'h0000_0080) begin n_fail++; $display("FAIL mip_ro got %h exp 00000080", rdata_o); end
      irq_timer_i = 1'b0;
   endtask

   task automatic test_counters();
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'hFFFF_FFFF);
      rd(12'hC80);
      n_chk++; if (rdata_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_hi_wr got %h exp ffffffff", rdata_o); end
      rd(12'hB00);
      tick();
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo got %h exp 0", rdata_o); end
      rd(12'hB80);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_hi got %h exp 0", rdata_o); end
      wr(12'hB02, 32'd5);
      instret_i = 1'b1; tick(); tick(); tick(); instret_i = 1'b0;
      rd(12'hC02);
      n_chk++; if (rdata_o !== 32'd8) begin n_fail++; $display("FAIL minstret got %h exp 8", rdata_o); end
      wr(12'hB02, 32'hFFFF_FFFF);
      wr(12'hB82, 32'd1);
      instret_i = 1'b1; tick(); instret_i = 1'b0;
      rd(12'hB82);
      n_chk++; if (rdata_o !== 32'd2) begin n_fail++; $display("FAIL minstret_carry got %h exp 2", rdata_o); end
      instret_i = 1'b1; wr(12'hB02, 32'd7); instret_i = 1'b0;
      rd(12'hB02);
      n_chk++; if (rdata_o !== 32'd7) begin n_fail++; $display("FAIL minstret_wr_wins got %h exp 7", rdata_o); end
      rd(12'hB82);
      n_chk++; if (rdata_o !== 32'd2) begin n_fail++; $display("FAIL minstret_hi_hold got %h exp 2", rdata_o); end
      rd(12'h7C0);
      n_chk++; if (rdata_o !== 32'h0 || illegal_csr_o !== 1'b1) begin n_fail++; $display("FAIL unmapped got %h %b exp 0 1", rdata_o, illegal_csr_o); end
   endtask

   task automatic test_reset_override();
      rst_i = 1'b1;
      wr(12'h340, 32'h0000_0055);
      rst_i = 1'b0;
      rd(12'h340);
      n_chk++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_override got %h exp 0", rdata_o); end
      rd(12'h305);
      n_chk++; if (rdata_o !== 32'h0000_0100) begin n_fail++; $display("FAIL rst_mtvec2 got %h exp 00000100", rdata_o); end
   endtask

   initial begin
      test_reset();
      test_mtvec_mepc();
      test_mstatus();
      test_trap_priority();
      test_mip();
      test_counters();
      test_reset_override();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
